// File: rtl/ysyx_22051013_trap_ctrl.sv
// ysyx_22051013_trap_ctrl: ecall/mret/timer-irq trap sequencer (drain, CSR commit, fetch redirect)
// Optional irq path: define YSYX_22051013_TRAP_IRQ_EN; otherwise only ecall and mret are sequenced.
module ysyx_22051013_trap_ctrl #(
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic [63:0] trap_pc_i,
  input  logic        irq_i,
  input  logic [63:0] irq_pc_i,
  input  logic        pipe_empty_i,
  input  logic [63:0] csr_rdata_i,
  input  logic        redir_ready_i,
  output logic [3:0]  csr_ctl_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_wdata_o,
  output logic [63:0] mcause_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redir_valid_o,
  output logic [63:0] redir_pc_o,
  output logic        busy_o,
  output logic        drain_timeout_o
);
  localparam int CW = $clog2(DRAIN_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);
  localparam logic [63:0] CAUSE_ECALL = 64'd11;
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_ECALL, K_MRET, K_IRQ} kind_t;
  state_t        state;
  kind_t         kind, ev_kind;
  logic [63:0]   epc, target, ev_pc;
  logic [CW-1:0] drain_cnt;
  logic          first, timeout, ev;
  logic          commit, trap;
`ifdef YSYX_22051013_TRAP_IRQ_EN
  localparam logic [63:0] CAUSE_IRQ = 64'h8000_0000_0000_0007;
  logic unused;
  assign unused  = ^csr_rdata_i[1:0];
  assign ev      = irq_i | ecall_i | mret_i;
  assign ev_kind = irq_i ? K_IRQ : ecall_i ? K_ECALL : K_MRET;
  assign ev_pc   = irq_i ? irq_pc_i : trap_pc_i;
`else
  logic unused;
  assign unused  = ^{irq_i, irq_pc_i, csr_rdata_i[1:0]};
  assign ev      = ecall_i | mret_i;
  assign ev_kind = ecall_i ? K_ECALL : K_MRET;
  assign ev_pc   = trap_pc_i;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= K_ECALL;
      epc       <= '0;
      target    <= '0;
      drain_cnt <= '0;
      first     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ev) begin
          state     <= DRAIN;
          kind      <= ev_kind;
          epc       <= ev_pc;
          drain_cnt <= '0;
          first     <= 1'b1;
        end
        DRAIN: begin
          first     <= 1'b0;
          drain_cnt <= drain_cnt + 1'b1;
          if (pipe_empty_i || drain_cnt == CNT_LAST) begin
            state <= COMMIT;
            if (!pipe_empty_i) timeout <= 1'b1;
          end
        end
        COMMIT: begin
          target <= {csr_rdata_i[63:2], 2'b00};
          state  <= REDIRECT;
        end
        default: if (redir_ready_i) state <= IDLE;
      endcase
    end
  end
  assign commit = state == COMMIT;
  assign trap   = kind != K_MRET;
  assign csr_ctl_o   = commit ? (trap ? 4'b0010 : 4'b0001) : 4'b0000;
  assign csr_addr_o  = commit ? (trap ? 12'h305 : 12'h341) : 12'h000;
  assign csr_wdata_o = (commit && trap) ? epc : 64'd0;
`ifdef YSYX_22051013_TRAP_IRQ_EN
  assign mcause_o    = (commit && trap) ? (kind == K_IRQ ? CAUSE_IRQ : CAUSE_ECALL) : 64'd0;
`else
  assign mcause_o    = (commit && trap) ? CAUSE_ECALL : 64'd0;
`endif
  assign flush_o         = first;
  assign busy_o          = state != IDLE;
  assign stall_o         = state != IDLE;
  assign redir_valid_o   = state == REDIRECT;
  assign redir_pc_o      = target;
  assign drain_timeout_o = timeout;
endmodule

// File: tb/tb_ysyx_22051013_trap_ctrl.sv
// tb_ysyx_22051013_trap_ctrl: directed scoreboard bench for the trap sequencer (DRAIN_MAX = 4)
module tb_ysyx_22051013_trap_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ecall_i = 1'b0, mret_i = 1'b0, irq_i = 1'b0, pipe_empty_i = 1'b1, redir_ready_i = 1'b1;
  logic [63:0] trap_pc_i = '0, irq_pc_i = '0, csr_rdata_i = '0;
  logic [3:0]  csr_ctl_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o, mcause_o, redir_pc_o;
  logic        flush_o, stall_o, redir_valid_o, busy_o, drain_timeout_o;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0]  ctl;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] cause;
    logic [63:0] pc;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  ysyx_22051013_trap_ctrl #(.DRAIN_MAX(4)) dut (
    .clk(clk), .rst(rst), .ecall_i(ecall_i), .mret_i(mret_i), .trap_pc_i(trap_pc_i),
    .irq_i(irq_i), .irq_pc_i(irq_pc_i), .pipe_empty_i(pipe_empty_i), .csr_rdata_i(csr_rdata_i),
    .redir_ready_i(redir_ready_i), .csr_ctl_o(csr_ctl_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .mcause_o(mcause_o), .flush_o(flush_o), .stall_o(stall_o),
    .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o), .busy_o(busy_o),
    .drain_timeout_o(drain_timeout_o)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, 64'(csr_ctl_o), 64'd0);
    chk({tag, "_addr"}, 64'(csr_addr_o), 64'd0);
    chk({tag, "_wdata"}, csr_wdata_o, 64'd0);
    chk({tag, "_mcause"}, mcause_o, 64'd0);
    chk({tag, "_flags"}, 64'({flush_o, stall_o, redir_valid_o, busy_o, drain_timeout_o}), 64'd0);
    chk({tag, "_redir_pc"}, redir_pc_o, 64'd0);
  endtask
  task automatic push(input logic [3:0] c, input logic [11:0] a, input logic [63:0] w,
                      input logic [63:0] m, input logic [63:0] p);
    exp_t x;
    x.ctl = c; x.addr = a; x.wdata = w; x.cause = m; x.pc = p;
    sbq.push_back(x);
  endtask
  // waits (bounded) for the commit cycle, pops the expected record and checks the CSR controls
  task automatic wait_commit(input string tag, output exp_t x);
    for (int i = 0; i < 40 && csr_ctl_o == 4'b0000; i++) step;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd1);
      x.ctl = 4'hf; x.addr = '1; x.wdata = '1; x.cause = '1; x.pc = '1;
    end else x = sbq.pop_front();
    chk({tag, "_ctl"}, 64'(csr_ctl_o), 64'(x.ctl));
    chk({tag, "_addr"}, 64'(csr_addr_o), 64'(x.addr));
    if (x.ctl == 4'b0010) begin
      chk({tag, "_wdata"}, csr_wdata_o, x.wdata);
      chk({tag, "_mcause"}, mcause_o, x.cause);
    end
  endtask
  // events already driven; pipe empty and fetch ready
  task automatic do_txn(input string tag);
    exp_t x;
    step;
    ecall_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0;
    chk({tag, "_flush"}, 64'(flush_o), 64'd1);
    chk({tag, "_busy"}, 64'({busy_o, stall_o}), 64'd3);
    step;
    chk({tag, "_flush_once"}, 64'(flush_o), 64'd0);
    wait_commit(tag, x);
    step;
    chk({tag, "_redir_valid"}, 64'(redir_valid_o), 64'd1);
    chk({tag, "_redir_pc"}, redir_pc_o, x.pc);
    chk({tag, "_ctl_after"}, 64'(csr_ctl_o), 64'd0);
    step;
    chk({tag, "_idle"}, 64'({busy_o, redir_valid_o}), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    step; step;
    chk_idle_outputs("reset");
    rst = 1'b0;
    step;
    chk_idle_outputs("post_reset");
    // ecall with fetch already ready in IDLE
    ecall_i = 1'b1; trap_pc_i = 64'h8000_0010; csr_rdata_i = 64'h8000_0103;
    push(4'b0010, 12'h305, 64'h8000_0010, 64'd11, 64'h8000_0100);
    do_txn("ecall");
    // mret
    mret_i = 1'b1; trap_pc_i = 64'h8000_0050; csr_rdata_i = 64'h8000_0014;
    push(4'b0001, 12'h341, 64'd0, 64'd0, 64'h8000_0014);
    do_txn("mret");
    // simultaneous events
    irq_i = 1'b1; ecall_i = 1'b1; mret_i = 1'b1;
    irq_pc_i = 64'h8000_0020; trap_pc_i = 64'h8000_0030; csr_rdata_i = 64'h8000_0202;
`ifdef YSYX_22051013_TRAP_IRQ_EN
    push(4'b0010, 12'h305, 64'h8000_0020, 64'h8000_0000_0000_0007, 64'h8000_0200);
`else
    push(4'b0010, 12'h305, 64'h8000_0030, 64'd11, 64'h8000_0200);
`endif
    do_txn("prio");
    // forced commit after DRAIN_MAX cycles
    pipe_empty_i = 1'b0; ecall_i = 1'b1; trap_pc_i = 64'h8000_0060; csr_rdata_i = 64'h8000_0400;
    push(4'b0010, 12'h305, 64'h8000_0060, 64'd11, 64'h8000_0400);
    step;
    ecall_i = 1'b0;
    chk("to_flush", 64'(flush_o), 64'd1);
    chk("to_sticky_early", 64'(drain_timeout_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("to_drain_ctl", 64'(csr_ctl_o), 64'd0);
      chk("to_drain_busy", 64'(busy_o), 64'd1);
    end
    step;
    chk("to_commit_cycle", 64'(csr_ctl_o), 64'b0010);
    chk("to_sticky", 64'(drain_timeout_o), 64'd1);
    wait_commit("to", e);
    pipe_empty_i = 1'b1;
    step;
    chk("to_redir_pc", redir_pc_o, e.pc);
    step; step;
    chk("to_sticky_hold", 64'(drain_timeout_o), 64'd1);
    chk("to_idle", 64'(busy_o), 64'd0);
    // fetch backpressure with a dropped ecall during the wait
    redir_ready_i = 1'b0; ecall_i = 1'b1; trap_pc_i = 64'h8000_0040; csr_rdata_i = 64'h8000_0301;
    push(4'b0010, 12'h305, 64'h8000_0040, 64'd11, 64'h8000_0300);
    step;
    ecall_i = 1'b0;
    step;
    wait_commit("bp", e);
    step;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(redir_valid_o), 64'd1);
      chk("bp_pc", redir_pc_o, e.pc);
      ecall_i = (i == 2);
      trap_pc_i = 64'h8000_0ff0;
      step;
    end
    ecall_i = 1'b0;
    chk("bp_still_valid", 64'(redir_valid_o), 64'd1);
    redir_ready_i = 1'b1;
    step;
    chk("bp_accept_idle", 64'({busy_o, redir_valid_o}), 64'd0);
    step;
    chk("bp_pulse_dropped", 64'({busy_o, flush_o}), 64'd0);
    chk("bp_sb_empty", 64'(sbq.size()), 64'd0);
    // reset during DRAIN
    pipe_empty_i = 1'b0; ecall_i = 1'b1; trap_pc_i = 64'h8000_0070;
    step;
    ecall_i = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0; pipe_empty_i = 1'b1;
    chk_idle_outputs("mid_rst");
    step;
    chk_idle_outputs("mid_rst_after");
    ecall_i = 1'b1; trap_pc_i = 64'h8000_0080; csr_rdata_i = 64'h8000_0500;
    push(4'b0010, 12'h305, 64'h8000_0080, 64'd11, 64'h8000_0500);
    do_txn("fresh");
    chk("final_sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
